// File: rtl/rd_pkg.sv
// Shared types for the round-robin read descriptor scheduler.
package rd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } sched_state_e;

    localparam int DESC_W = 96;

    typedef struct packed {
        logic [31:0] control;
        logic [31:0] addr;
        logic [31:0] len;
    } desc_t;

endpackage

// File: rtl/rd_sched_rr_arbiter.sv
// Combinational round-robin pick: the first set req bit after ptr wins, wrapping modulo NUM_REQ.
module rr_arbiter
    import rd_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               any_req
);

    logic            found;
    logic [ID_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        // ptr itself is the last served requester, so it is searched last.
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = ID_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/rd_sched.sv
// Round-robin descriptor scheduler feeding the packet reader; one descriptor in flight at a time.
// Optional WAIT watchdog is compiled in with `define SCHED_TIMEOUT_EN.
module rd_sched
    import rd_pkg::*;
#(
    parameter int NUM_REQ     = 4,
`ifdef SCHED_TIMEOUT_EN
    parameter int TIMEOUT_CYC = 4096,
`endif
    parameter int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_control,
    input  logic [NUM_REQ*32-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0] req_len,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    req_done,
    output logic                  rd_start,
    output logic [31:0]           rd_control,
    output logic [31:0]           rd_pkt_addr,
    output logic [31:0]           rd_pkt_len,
    input  logic                  rd_done,
    output logic                  busy,
    output logic [ID_W-1:0]       grant_id,
    output logic                  err_timeout
);

    sched_state_e         state, state_nxt;
    logic [ID_W-1:0]      ptr;
    logic [ID_W-1:0]      gid;
    logic [NUM_REQ-1:0]   gid_onehot;
    desc_t                desc, desc_sel;
    logic [NUM_REQ-1:0]   arb_grant;
    logic [ID_W-1:0]      arb_idx;
    logic                 arb_any;
    logic                 wait_expired;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_req   (arb_any)
    );

    always_comb begin
        desc_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                desc_sel.control = desc_sel.control | req_control[32*i +: 32];
                desc_sel.addr    = desc_sel.addr    | req_addr[32*i +: 32];
                desc_sel.len     = desc_sel.len     | req_len[32*i +: 32];
            end
        end
    end

    assign gid_onehot = NUM_REQ'(1) << gid;

    // Handshake: a requester holds req_valid and its descriptor stable until its
    // req_ready pulse; ready pulses once per descriptor, in the cycle after capture.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        req_done  = '0;
        rd_start  = 1'b0;
        case (state)
            IDLE: begin
                if (arb_any) state_nxt = ISSUE;
            end
            ISSUE: begin
                req_ready = gid_onehot;
                if (desc.len != '0) begin
                    rd_start  = 1'b1;
                    state_nxt = WAIT;
                end else begin
                    state_nxt = RELEASE;
                end
            end
            WAIT: begin
                if (rd_done || wait_expired) state_nxt = RELEASE;
            end
            RELEASE: begin
                req_done  = gid_onehot;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            ptr   <= ID_W'(NUM_REQ - 1);
            gid   <= '0;
            desc  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && arb_any) begin
                desc <= desc_sel;
                gid  <= arb_idx;
            end
            if (state == RELEASE) ptr <= gid;
        end
    end

`ifdef SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // ISSUE is the only way into WAIT, so clearing there clears on WAIT entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == ISSUE) wait_cnt <= '0;
            else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
            if (state == WAIT && wait_expired && !rd_done) err_q <= 1'b1;
        end
    end

    assign err_timeout = err_q;
`else
    assign wait_expired = 1'b0;
    assign err_timeout  = 1'b0;
`endif

    assign busy        = (state != IDLE);
    assign grant_id    = gid;
    assign rd_control  = desc.control;
    assign rd_pkt_addr = desc.addr;
    assign rd_pkt_len  = desc.len;

endmodule

// File: tb/tb_rd_sched.sv
// Self-checking bench for rd_sched: per-cycle timeline model plus directed scenarios.
// Timeout scenario is built when SCHED_TIMEOUT_EN is defined.
module tb_rd_sched;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int EW      = 2 * NUM_REQ + 2;
`ifdef SCHED_TIMEOUT_EN
    localparam int TO_CYC  = 16;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*32-1:0] req_control;
    logic [NUM_REQ*32-1:0] req_addr;
    logic [NUM_REQ*32-1:0] req_len;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    req_done;
    logic                  rd_start;
    logic [31:0]           rd_control;
    logic [31:0]           rd_pkt_addr;
    logic [31:0]           rd_pkt_len;
    logic                  rd_done;
    logic                  busy;
    logic [ID_W-1:0]       grant_id;
    logic                  err_timeout;

    rd_sched #(
        .NUM_REQ     (NUM_REQ)
`ifdef SCHED_TIMEOUT_EN
        , .TIMEOUT_CYC (TO_CYC)
`endif
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_control (req_control),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .req_ready   (req_ready),
        .req_done    (req_done),
        .rd_start    (rd_start),
        .rd_control  (rd_control),
        .rd_pkt_addr (rd_pkt_addr),
        .rd_pkt_len  (rd_pkt_len),
        .rd_done     (rd_done),
        .busy        (busy),
        .grant_id    (grant_id),
        .err_timeout (err_timeout)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
        int r = -1;
        for (int i = 0; i < NUM_REQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    // ---------------- timeline model ----------------
    // Each queued entry is one future cycle's pulse pattern {busy, start, ready, done};
    // with nothing queued the scheduler is either idle or waiting on the reader.
    logic [EW-1:0] exp_q[$];
    bit            m_waiting;
    int            m_wait_n;
    int            m_last;
    int            m_gid;
    logic [31:0]   m_ctl, m_addr, m_len;
    logic          m_err;
    int            grant_log[$];

    task automatic model_reset();
        exp_q.delete();
        m_waiting = 1'b0;
        m_wait_n  = 0;
        m_last    = NUM_REQ - 1;
        m_gid     = 0;
        m_ctl     = '0;
        m_addr    = '0;
        m_len     = '0;
        m_err     = 1'b0;
    endtask

    task automatic push_release();
        exp_q.push_back({1'b1, 1'b0, {NUM_REQ{1'b0}}, NUM_REQ'(1) << m_gid});
        m_waiting = 1'b0;
    endtask

    task automatic model_arbitrate();
        int w = -1;
        for (int i = 1; i <= NUM_REQ; i++)
            if (w < 0 && req_valid[(m_last + i) % NUM_REQ]) w = (m_last + i) % NUM_REQ;
        m_gid  = w;
        m_last = w;
        m_ctl  = req_control[32*w +: 32];
        m_addr = req_addr[32*w +: 32];
        m_len  = req_len[32*w +: 32];
        exp_q.push_back({1'b1, (m_len != 0), NUM_REQ'(1) << w, {NUM_REQ{1'b0}}});
        if (m_len == 0) begin
            push_release();
        end else begin
            m_waiting = 1'b1;
            m_wait_n  = 0;
        end
    endtask

    initial model_reset();

    always @(negedge clk) begin
        logic [EW-1:0] e;
        bit            popped;
        popped = (exp_q.size() > 0);
        if (popped) e = exp_q.pop_front();
        else        e = {m_waiting, 1'b0, {NUM_REQ{1'b0}}, {NUM_REQ{1'b0}}};
        if (chk_en) begin
            check("busy",        32'(busy),        32'(e[EW-1]));
            check("rd_start",    32'(rd_start),    32'(e[EW-2]));
            check("req_ready",   32'(req_ready),   32'(e[2*NUM_REQ-1:NUM_REQ]));
            check("req_done",    32'(req_done),    32'(e[NUM_REQ-1:0]));
            check("grant_id",    32'(grant_id),    32'(m_gid));
            check("rd_control",  rd_control,       m_ctl);
            check("rd_pkt_addr", rd_pkt_addr,      m_addr);
            check("rd_pkt_len",  rd_pkt_len,       m_len);
            check("err_timeout", 32'(err_timeout), 32'(m_err));
            if (|req_ready) grant_log.push_back(onehot_idx(req_ready));
        end
        if (!reset) begin
            model_reset();
        end else if (!popped) begin
            if (m_waiting) begin
                m_wait_n++;
                if (rd_done) push_release();
`ifdef SCHED_TIMEOUT_EN
                else if (m_wait_n == TO_CYC) begin
                    push_release();
                    m_err = 1'b1;
                end
`endif
            end else if (req_valid != '0) begin
                model_arbitrate();
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic set_desc(input int i, input logic [31:0] c, input logic [31:0] a,
                            input logic [31:0] l);
        req_control[32*i +: 32] = c;
        req_addr[32*i +: 32]    = a;
        req_len[32*i +: 32]     = l;
    endtask

    task automatic wait_start(input int bound);
        bit ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (rd_start) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_start: no rd_start within %0d cycles (cycle %0d)", bound, cyc);
        end
    endtask

    task automatic pulse_done_after(input int d);
        repeat (d) tick();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        reset       = 1'b0;
        req_valid   = '0;
        req_control = '0;
        req_addr    = '0;
        req_len     = '0;
        rd_done     = 1'b0;
        repeat (2) tick();
        chk_en = 1'b1;

        // reset state
        check("rst_busy",     32'(busy),        0);
        check("rst_ready",    32'(req_ready),   0);
        check("rst_done",     32'(req_done),    0);
        check("rst_start",    32'(rd_start),    0);
        check("rst_grant",    32'(grant_id),    0);
        check("rst_addr",     rd_pkt_addr,      0);
        check("rst_len",      rd_pkt_len,       0);
        check("rst_ctl",      rd_control,       0);
        check("rst_err",      32'(err_timeout), 0);
        reset = 1'b1;
        tick();

        // single request from requester 2
        set_desc(2, 32'h0000_00C2, 32'h0000_1000, 32'd64);
        req_valid = 4'b0100;
        tick();
        check("t1_ready", 32'(req_ready), 32'h4);
        check("t1_start", 32'(rd_start),  1);
        check("t1_addr",  rd_pkt_addr,    32'h1000);
        check("t1_len",   rd_pkt_len,     32'd64);
        check("t1_gid",   32'(grant_id),  2);
        req_valid = '0;
        repeat (10) tick();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        check("t1_done", 32'(req_done), 32'h4);
        check("t1_busy_rel", 32'(busy), 1);
        tick();
        check("t1_busy_idle", 32'(busy), 0);
        check("t1_addr_hold", rd_pkt_addr, 32'h1000);

        // round robin with all requesters pending
        do_reset();
        for (int i = 0; i < NUM_REQ; i++)
            set_desc(i, 32'hC000_0000 + 32'(i), 32'h100 * 32'(i + 1), 32'(16 * (i + 1)));
        grant_log.delete();
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            wait_start(20);
            if (k == 4) req_valid = '0;
            pulse_done_after(3);
        end
        repeat (3) tick();
        check("rr_count", 32'(grant_log.size()), 5);
        if (grant_log.size() == 5) begin
            check("rr_g0", 32'(grant_log[0]), 0);
            check("rr_g1", 32'(grant_log[1]), 1);
            check("rr_g2", 32'(grant_log[2]), 2);
            check("rr_g3", 32'(grant_log[3]), 3);
            check("rr_g4", 32'(grant_log[4]), 0);
        end

        // zero length descriptor skips WAIT
        set_desc(1, 32'h0000_0011, 32'h0000_2000, 32'd0);
        req_valid = 4'b0010;
        tick();
        check("z_ready", 32'(req_ready), 32'h2);
        check("z_start", 32'(rd_start),  0);
        req_valid = '0;
        tick();
        check("z_done", 32'(req_done), 32'h2);
        tick();
        check("z_idle", 32'(busy), 0);

        // spurious rd_done in IDLE and ISSUE
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        check("sp_idle_busy", 32'(busy), 0);
        set_desc(3, 32'h0000_0033, 32'h0000_3000, 32'd8);
        req_valid = 4'b1000;
        tick();
        check("sp_ready", 32'(req_ready), 32'h8);
        req_valid = '0;
        rd_done   = 1'b1;
        tick();
        rd_done = 1'b0;
        check("sp_wait_busy", 32'(busy), 1);
        check("sp_wait_done", 32'(req_done), 0);
        pulse_done_after(2);
        check("sp_done", 32'(req_done), 32'h8);
        tick();

        // reset during WAIT restores the pointer
        set_desc(0, 32'h0000_0044, 32'h0000_4000, 32'd4);
        req_valid = 4'b0001;
        wait_start(10);
        req_valid = '0;
        pulse_done_after(2);
        tick();
        set_desc(1, 32'h0000_0055, 32'h0000_5000, 32'd12);
        req_valid = 4'b0010;
        wait_start(10);
        req_valid = '0;
        repeat (3) tick();
        check("rw_in_wait", 32'(busy), 1);
        reset = 1'b0;
        tick();
        check("rw_busy",  32'(busy),      0);
        check("rw_done",  32'(req_done),  0);
        check("rw_gid",   32'(grant_id),  0);
        check("rw_addr",  rd_pkt_addr,    0);
        reset     = 1'b1;
        req_valid = 4'b0011;
        tick();
        check("rw_ready", 32'(req_ready), 32'h1);
        check("rw_gid2",  32'(grant_id),  0);
        req_valid = '0;
        pulse_done_after(1);
        repeat (2) tick();

`ifdef SCHED_TIMEOUT_EN
        // reader never completes
        begin
            int n = 0;
            set_desc(0, 32'h0000_0066, 32'h0000_6000, 32'd4);
            req_valid = 4'b0001;
            wait_start(10);
            req_valid = '0;
            for (int i = 0; i < 40; i++) begin
                tick();
                n++;
                if (req_done != '0) break;
            end
            check("to_cycles", 32'(n),           32'd17);
            check("to_done",   32'(req_done),    32'h1);
            check("to_err",    32'(err_timeout), 1);
            tick();
            set_desc(2, 32'h0000_0077, 32'h0000_7000, 32'd4);
            req_valid = 4'b0100;
            wait_start(10);
            req_valid = '0;
            pulse_done_after(2);
            check("to_done2",  32'(req_done),    32'h4);
            check("to_sticky", 32'(err_timeout), 1);
            repeat (2) tick();
        end
`endif

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
